// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: shift-add multiply and restoring divide,
// one bit per cycle, with HI/LO result registers for MFHI/MFLO.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W = DATA_WIDTH;
    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DZERO
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] counter;
    logic [2*W-1:0]       acc;
    logic [W-1:0]         opnd;
    logic                 sa_q;
    logic                 sb_q;
    logic                 is_div;

    logic         sa_in;
    logic         sb_in;
    logic [W-1:0] abs_a;
    logic [W-1:0] abs_b;
    logic [W:0]   mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]   div_shift;
    logic [W:0]   div_diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0] quot_fixed;
    logic [W-1:0] rem_fixed;
    logic [W-1:0] res_hi;
    logic [W-1:0] res_lo;

    always_comb begin
        sa_in = op[0] & operand_a[W-1];
        sb_in = op[0] & operand_b[W-1];
        abs_a = sa_in ? (~operand_a + W'(1)) : operand_a;
        abs_b = sb_in ? (~operand_b + W'(1)) : operand_b;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}; the carry
    // of each add lands in the bit vacated by the right shift.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        mul_next = {mul_sum, acc[W-1:1]};
    end

    // Divide: acc = {partial remainder, dividend shifting out / quotient shifting in}.
    always_comb begin
        div_shift = {acc[2*W-1:W], acc[W-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (div_diff[W]) begin
            div_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            div_next = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        end
    end

    always_comb begin
        prod_fixed = (sa_q ^ sb_q) ? (~acc + {{(2*W-1){1'b0}}, 1'b1}) : acc;
        quot_fixed = (sa_q ^ sb_q) ? (~acc[W-1:0] + W'(1)) : acc[W-1:0];
        rem_fixed  = sa_q ? (~acc[2*W-1:W] + W'(1)) : acc[2*W-1:W];
        if (is_div) begin
            res_hi = rem_fixed;
            res_lo = quot_fixed;
        end else begin
            res_hi = prod_fixed[2*W-1:W];
            res_lo = prod_fixed[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            counter     <= '0;
            acc         <= '0;
            opnd        <= '0;
            sa_q        <= 1'b0;
            sb_q        <= 1'b0;
            is_div      <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa_q    <= sa_in;
                        sb_q    <= sb_in;
                        is_div  <= op[1];
                        counter <= '0;
                        busy    <= 1'b1;
                        if (op[1] && (operand_b == '0)) begin
                            // Divide by zero resolves immediately with raw dividend in HI.
                            state       <= DZERO;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            hi          <= operand_a;
                            lo          <= '1;
                        end else begin
                            state <= CALC;
                            opnd  <= op[1] ? abs_b : abs_a;
                            acc   <= {{W{1'b0}}, (op[1] ? abs_a : abs_b)};
                        end
                    end
                end
                CALC: begin
                    acc     <= is_div ? div_next : mul_next;
                    counter <= counter + 1'b1;
                    if (counter == LAST_ITER) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                DZERO: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit for the MIPS datapath; it is the sequential companion of the ALU control decoder.
- When the control unit decodes MULT/MULTU/DIV/DIVU, it pulses start. The unit iterates one bit per cycle and writes the HI/LO result registers.
- HI/LO feed MFHI/MFLO directly. busy drives the pipeline/PC stall.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width (>=2).
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  00=MULTU, 01=MULT, 10=DIVU, 11=DIV; sampled with start.
- operand_a  input  DATA_WIDTH  multiplicand / dividend (rs); sampled with start.
- operand_b  input  DATA_WIDTH  multiplier / divisor (rt); sampled with start.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO are updated.
- div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with operand_b==0.
- hi  output  DATA_WIDTH  HI register (product upper half / remainder).
- lo  output  DATA_WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; counter=0.
  - Reset has priority over every other input, including mid-operation.
  - A reset mid-operation aborts the operation and produces no done.
- States:
  - IDLE -> CALC on start, when operand_b!=0 or op is a multiply.
  - IDLE -> DZERO on start with op[1]=1 and operand_b==0.
  - CALC -> FIX after DATA_WIDTH iterations.
  - FIX -> IDLE.
  - DZERO -> IDLE.
- Accept cycle (IDLE, start=1):
  - Latch op and sign flags sa=op[0]&a[MSB], sb=op[0]&b[MSB].
  - Latch magnitudes |a| and |b|; signed ops take the two's complement when the sign flag is set.
  - Clear the accumulator; counter=0; busy=1 from the next cycle.
- CALC, multiply: shift-add, one multiplier bit per cycle, 2*DATA_WIDTH-bit unsigned accumulator.
- CALC, divide: restoring division, one quotient bit per cycle, DATA_WIDTH+1-bit partial remainder.
- FIX, multiply: negate the 2W product if sa^sb. hi=product[2W-1:W], lo=product[W-1:0].
- FIX, divide:
  - Quotient negated if sa^sb; remainder negated if sa. This gives truncation toward zero and a remainder carrying the dividend's sign.
  - hi=remainder, lo=quotient.
- FIX timing: hi/lo are registered at the end of FIX. done=1 and busy=0 in the following cycle (IDLE).
- Latency: start in cycle 0 -> done high in cycle DATA_WIDTH+2 (34 for W=32). hi/lo are valid from that cycle.
- DZERO:
  - Next cycle (cycle 1 after start): lo={W{1}}, hi=operand_a (raw), done=1, div_by_zero=1.
  - busy is high only for the DZERO cycle.
- DIV overflow (most-negative / -1): no special case. Result is lo=most-negative (wrap), hi=0.
- Input rules:
  - start while busy=1 is ignored; operands are not re-sampled.
  - start in the cycle done=1 (state IDLE) is accepted.
  - operand_a/operand_b/op may change freely after the accept cycle.
- hi/lo hold their value between operations. They change only at the completion of FIX or DZERO, or on reset.
- No arithmetic output is ever X after reset.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 1 for cycles 1..33; done pulse at cycle 34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 (0xFFFFFFFD) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14 (0xE), hi=2.
- DIVU 100/0 -> done and div_by_zero at cycle 1; lo=0xFFFFFFFF, hi=0x64; busy high only in cycle 1.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; no div_by_zero.
- Control:
  - start pulsed again at cycle 5 of a MULTU with new operands -> ignored; original result at cycle 34.
  - reset at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0; no done.
  - Back-to-back start in the done cycle -> accepted; second done 34 cycles later.
